// File: rtl/sys_timer_pkg.sv
// Shared definitions for the interval-timer sequencer.
//   - state_e   : sequencer FSM state encoding
//   - ADDR_*    : register addresses of the 16-bit interval-timer slave
//   - CTRL_*    : bit positions inside the timer control register
//   - ctrl_word : builds a control register value from individual bits
package sys_timer_pkg;

  typedef enum logic [3:0] {
    IDLE,
    W_STOP,
    W_PL,
    W_PH,
    W_CLR,
    W_CTRL,
    RUN,
    ACK,
    GUARD,
    S_WR,
    S_RDL,
    S_RDH,
    S_DONE,
    X_CTRL,
    X_CLR
  } state_e;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_PERIODL = 3'd2;
  localparam logic [2:0] ADDR_PERIODH = 3'd3;
  localparam logic [2:0] ADDR_SNAPL   = 3'd4;
  localparam logic [2:0] ADDR_SNAPH   = 3'd5;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  function automatic logic [15:0] ctrl_word(input logic ito, input logic cont,
                                            input logic start, input logic stop);
    logic [15:0] w;
    w             = 16'h0000;
    w[CTRL_ITO]   = ito;
    w[CTRL_CONT]  = cont;
    w[CTRL_START] = start;
    w[CTRL_STOP]  = stop;
    return w;
  endfunction

endpackage

// File: rtl/sys_timer_sequencer.sv
// Sequencer that programs and services a 16-bit Avalon-MM interval timer.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   cfg_start/stop/snap   : one-cycle command pulses
//   cfg_period            : timer period, 0 selects DEFAULT_PERIOD
//   cfg_continuous        : 1 = periodic, 0 = one-shot
//   tm_address/chipselect/write_n/writedata, tm_readdata : Avalon-MM master
//   tm_irq                : timer interrupt (level)
//   busy, running         : sequencer status
//   tick, tick_count      : one-cycle pulse per serviced timeout, wrapping count
//   snap_value/snap_valid : captured live counter and its one-cycle strobe
// All outputs are registered; they are decoded from the state being entered
// so each output matches the FSM state during that state's cycle.
module sys_timer_sequencer
  import sys_timer_pkg::*;
#(
  parameter logic [31:0] DEFAULT_PERIOD = 32'd100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_start,
  input  logic        cfg_stop,
  input  logic        cfg_snap,
  input  logic [31:0] cfg_period,
  input  logic        cfg_continuous,
  output logic [2:0]  tm_address,
  output logic        tm_chipselect,
  output logic        tm_write_n,
  output logic [15:0] tm_writedata,
  input  logic [15:0] tm_readdata,
  input  logic        tm_irq,
  output logic        busy,
  output logic        running,
  output logic        tick,
  output logic [31:0] tick_count,
  output logic [31:0] snap_value,
  output logic        snap_valid
);

  state_e      state_q, state_d;
  logic [31:0] period_q;
  logic        cont_q;
  logic [2:0]  tm_address_q, tm_address_d;
  logic        tm_chipselect_q, tm_chipselect_d;
  logic        tm_write_n_q, tm_write_n_d;
  logic [15:0] tm_writedata_q, tm_writedata_d;
  logic        busy_q, running_q, tick_q, snap_valid_q;
  logic [31:0] tick_count_q, snap_value_q;

  // Next-state logic. In RUN a stop wins over an interrupt so a stop request
  // never produces a tick; the interrupt is a level, so one arriving during a
  // snapshot is still pending when the FSM returns to RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cfg_start) state_d = W_STOP;
      W_STOP:  state_d = W_PL;
      W_PL:    state_d = W_PH;
      W_PH:    state_d = W_CLR;
      W_CLR:   state_d = W_CTRL;
      W_CTRL:  state_d = RUN;
      RUN: begin
        if (cfg_stop)      state_d = X_CTRL;
        else if (tm_irq)   state_d = ACK;
        else if (cfg_snap) state_d = S_WR;
      end
      ACK:     state_d = GUARD;
      // The status clear lands at the end of ACK; GUARD lets the deasserted
      // irq settle before RUN samples it again.
      GUARD:   state_d = cont_q ? RUN : IDLE;
      S_WR:    state_d = S_RDL;
      S_RDL:   state_d = S_RDH;
      S_RDH:   state_d = S_DONE;
      S_DONE:  state_d = RUN;
      X_CTRL:  state_d = X_CLR;
      X_CLR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus decode for the state being entered.
  always_comb begin
    tm_chipselect_d = 1'b0;
    tm_write_n_d    = 1'b1;
    tm_address_d    = 3'd0;
    tm_writedata_d  = 16'h0000;
    case (state_d)
      W_STOP, X_CTRL: begin
        tm_chipselect_d = 1'b1;
        tm_write_n_d    = 1'b0;
        tm_address_d    = ADDR_CONTROL;
        tm_writedata_d  = ctrl_word(1'b0, 1'b0, 1'b0, 1'b1);
      end
      W_PL: begin
        tm_chipselect_d = 1'b1;
        tm_write_n_d    = 1'b0;
        tm_address_d    = ADDR_PERIODL;
        tm_writedata_d  = period_q[15:0];
      end
      W_PH: begin
        tm_chipselect_d = 1'b1;
        tm_write_n_d    = 1'b0;
        tm_address_d    = ADDR_PERIODH;
        tm_writedata_d  = period_q[31:16];
      end
      W_CLR, ACK, X_CLR: begin
        tm_chipselect_d = 1'b1;
        tm_write_n_d    = 1'b0;
        tm_address_d    = ADDR_STATUS;
      end
      W_CTRL: begin
        tm_chipselect_d = 1'b1;
        tm_write_n_d    = 1'b0;
        tm_address_d    = ADDR_CONTROL;
        tm_writedata_d  = ctrl_word(1'b1, cont_q, 1'b1, 1'b0);
      end
      S_WR: begin
        tm_chipselect_d = 1'b1;
        tm_write_n_d    = 1'b0;
        tm_address_d    = ADDR_SNAPL;
      end
      S_RDL: begin
        tm_chipselect_d = 1'b1;
        tm_address_d    = ADDR_SNAPL;
      end
      S_RDH: begin
        tm_chipselect_d = 1'b1;
        tm_address_d    = ADDR_SNAPH;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      period_q        <= 32'd0;
      cont_q          <= 1'b0;
      tm_address_q    <= 3'd0;
      tm_chipselect_q <= 1'b0;
      tm_write_n_q    <= 1'b1;
      tm_writedata_q  <= 16'h0000;
      busy_q          <= 1'b0;
      running_q       <= 1'b0;
      tick_q          <= 1'b0;
      tick_count_q    <= 32'd0;
      snap_value_q    <= 32'd0;
      snap_valid_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      tm_address_q    <= tm_address_d;
      tm_chipselect_q <= tm_chipselect_d;
      tm_write_n_q    <= tm_write_n_d;
      tm_writedata_q  <= tm_writedata_d;
      busy_q          <= !(state_d inside {IDLE, RUN});
      running_q       <= state_d inside {RUN, ACK, GUARD, S_WR, S_RDL, S_RDH, S_DONE};
      tick_q          <= (state_d == ACK);
      if (state_q == IDLE && cfg_start) begin
        period_q <= (cfg_period == 32'd0) ? DEFAULT_PERIOD : cfg_period;
        cont_q   <= cfg_continuous;
      end
      // Count moves together with the tick pulse; natural 32-bit wrap.
      if (state_d == ACK) tick_count_q <= tick_count_q + 32'd1;
      // Read data trails the address by one cycle, so each half is taken
      // in the state after the one that presented its address.
      if (state_q == S_RDH)  snap_value_q[15:0]  <= tm_readdata;
      if (state_q == S_DONE) snap_value_q[31:16] <= tm_readdata;
      snap_valid_q <= (state_q == S_DONE);
    end
  end

  assign tm_address    = tm_address_q;
  assign tm_chipselect = tm_chipselect_q;
  assign tm_write_n    = tm_write_n_q;
  assign tm_writedata  = tm_writedata_q;
  assign busy          = busy_q;
  assign running       = running_q;
  assign tick          = tick_q;
  assign tick_count    = tick_count_q;
  assign snap_value    = snap_value_q;
  assign snap_valid    = snap_valid_q;

endmodule

// File: doc/sys_timer_sequencer.md
SYS_TIMER_SEQUENCER -- requirements
Module: sys_timer_sequencer

Interface
REQ-001 SHALL have parameter DEFAULT_PERIOD, default 32'd100, the period loaded when cfg_period is zero.
REQ-002 SHALL have ports: clk  in  1  single system clock, all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 cfg_start  in  1  one-cycle pulse: program and start timer.
REQ-005 cfg_stop  in  1  one-cycle pulse: stop timer.
REQ-006 cfg_snap  in  1  one-cycle pulse: capture live counter.
REQ-007 cfg_period  in  32  period, sampled on accepted cfg_start.
REQ-008 cfg_continuous  in  1  periodic(1)/one-shot(0), sampled with cfg_period.
REQ-009 tm_address  out  3; tm_chipselect  out  1; tm_write_n  out  1; tm_writedata  out  16  Avalon-MM master to the 16-bit interval-timer slave.
REQ-010 tm_readdata  in  16  slave read data, valid exactly one cycle after the address is presented; tm_irq  in  1  timer interrupt, level.
REQ-011 busy  out  1; running  out  1; tick  out  1; tick_count  out  32; snap_value  out  32; snap_valid  out  1.

Function
REQ-012 SHALL use FSM states IDLE, W_STOP, W_PL, W_PH, W_CLR, W_CTRL, RUN, ACK, GUARD, S_WR, S_RDL, S_RDH, S_DONE, X_CTRL, X_CLR; each W_/S_WR/X_ state lasts exactly one cycle.
REQ-013 Write state: tm_chipselect=1, tm_write_n=0; read state: tm_chipselect=1, tm_write_n=1; all other states: tm_chipselect=0, tm_write_n=1, tm_address=0, tm_writedata=0.
REQ-014 IDLE + cfg_start: latch period (0 -> DEFAULT_PERIOD) and continuous; sequence W_STOP(addr1,16'h0008) -> W_PL(addr2,period[15:0]) -> W_PH(addr3,period[31:16]) -> W_CLR(addr0,16'h0000) -> W_CTRL(addr1,{12'h0,1'b0,1'b1,cont,1'b1}) -> RUN.
REQ-015 cfg_start outside IDLE, and cfg_stop/cfg_snap outside RUN, SHALL be ignored.
REQ-016 RUN priority: cfg_stop > tm_irq > cfg_snap.
REQ-017 RUN + tm_irq: ACK writes addr0,16'h0000; tick=1 during ACK only; tick_count increments by 1 in ACK, wrapping 32'hFFFFFFFF -> 0.
REQ-018 GUARD: one idle cycle (tm_irq ignored), then RUN if continuous else IDLE.
REQ-019 RUN + cfg_stop: X_CTRL(addr1,16'h0008) -> X_CLR(addr0,16'h0000) -> IDLE; no tick, even with simultaneous tm_irq.
REQ-020 RUN + cfg_snap: S_WR(addr4,16'h0000) -> S_RDL(addr4) -> S_RDH(addr5) -> S_DONE -> RUN; snap_value[15:0] captured from tm_readdata in S_RDH, [31:16] in S_DONE; snap_valid pulses one cycle in the cycle after S_DONE, with snap_value stable.
REQ-021 tm_irq arriving during a snapshot SHALL be serviced on return to RUN (level input, not lost).
REQ-022 busy=1 in every state except IDLE and RUN; running=1 in RUN, ACK, GUARD, S_*.
REQ-023 snap_value and tick_count SHALL hold their values until next update; tick_count is cleared only by reset.

Reset
REQ-024 reset SHALL force IDLE and clear all outputs and registers to 0 (tm_write_n=1), including mid-sequence; the half-written timer is re-programmed by the next cfg_start.
REQ-025 reset SHALL take priority over every input in the same cycle.

Structure
REQ-026 State encoding, timer register addresses (0..5) and control bit constants (ITO=0, CONT=1, START=2, STOP=3) SHALL live in a shared package, sys_timer_pkg.
REQ-027 SHALL be a single module; no sub-module.

Verification
REQ-028 Bench SHALL pair the block with the interval-timer slave model and cover the following.
REQ-029 cfg_start, cfg_period=32'h0001_0002, cont=1 -> writes (1,0008),(2,0002),(3,0001),(0,0000),(1,0007) on 5 consecutive cycles, then running=1.
REQ-030 cfg_period=10, cont=1, run 5 timeouts -> 5 tick pulses, tick_count=5, tm_irq cleared within 2 cycles of each.
REQ-031 cont=0 -> one tick, control write 0005, FSM returns to IDLE, busy=0, running=0.
REQ-032 cfg_stop and tm_irq in same RUN cycle -> writes (1,0008),(0,0000), no tick, IDLE.
REQ-033 cfg_snap with counter at 32'h0000_0042 -> snap_valid one cycle, snap_value=32'h0000_0042.
REQ-034 reset asserted during W_PH, tick_count preset to 32'hFFFFFFFF then one tick -> IDLE with all outputs 0 / tick_count wraps to 0.
